// File: rtl/reset_pulse_ctrl.sv
// Reset-assertion controller: turns edge-triggered reset requests into a
// minimum-width active-low pulse followed by a hold-off window, latching the cause bits.
module reset_pulse_ctrl #(
    parameter int REQ_WIDTH      = 4,
    parameter int ASSERT_CYCLES  = 248,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic                 iClk_2M,
    input  logic                 iRst,
    input  logic [REQ_WIDTH-1:0] iRstReq,
    input  logic [REQ_WIDTH-1:0] iRstMask,
    output logic                 oRst_n,
    output logic                 oBusy,
    output logic [REQ_WIDTH-1:0] oReqSrc,
    output logic                 oDone
);

    localparam int CNT_MAX = (ASSERT_CYCLES > HOLDOFF_CYCLES) ? ASSERT_CYCLES : HOLDOFF_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0]        A_TERM   = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0]        H_TERM   = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0]        CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [REQ_WIDTH-1:0] REQ_ZERO = {REQ_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [REQ_WIDTH-1:0]   req_prev_q, req_prev_d;
    logic [REQ_WIDTH-1:0]   pend_q, pend_d;
    logic [REQ_WIDTH-1:0]   src_q, src_d;
    logic                   rst_n_q, rst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [REQ_WIDTH-1:0]   edge_s;
    logic [REQ_WIDTH-1:0]   lvl_s;
    logic [REQ_WIDTH-1:0]   pend_acc_s;

    // Next-state, cause latching, pending accumulation and counter control
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        req_prev_d = iRstReq;
        edge_s     = iRstReq & ~req_prev_q & ~iRstMask;
        lvl_s      = iRstReq & ~iRstMask;
        pend_acc_s = pend_q | edge_s;

        case (state_q)
            ST_IDLE: begin
                if (edge_s != REQ_ZERO) begin
                    state_d = ST_ASSERT;
                    src_d   = edge_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                src_d = src_q | edge_s;
                // Once the minimum width is met, any live unmasked level stretches the pulse
                if ((cnt_q == A_TERM) && (lvl_s == REQ_ZERO)) begin
                    state_d = ST_HOLDOFF;
                end else begin
                    state_d = ST_ASSERT;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == H_TERM) begin
                    done_d = 1'b1;
                    pend_d = REQ_ZERO;
                    if (pend_acc_s != REQ_ZERO) begin
                        state_d = ST_ASSERT;
                        src_d   = pend_acc_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pend_d = pend_acc_s;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                src_d   = REQ_ZERO;
                pend_d  = REQ_ZERO;
            end
        endcase

        // Counter restarts on every state change and saturates at the state's terminal value
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if ((state_q == ST_ASSERT) && (cnt_q != A_TERM)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if ((state_q == ST_HOLDOFF) && (cnt_q != H_TERM)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        rst_n_d = (state_d != ST_ASSERT);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces a full power-on pulse
    always_ff @(posedge iClk_2M) begin
        if (iRst) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= CNT_ZERO;
            req_prev_q <= REQ_ZERO;
            pend_q     <= REQ_ZERO;
            src_q      <= REQ_ZERO;
            rst_n_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_prev_q <= req_prev_d;
            pend_q     <= pend_d;
            src_q      <= src_d;
            rst_n_q    <= rst_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign oRst_n  = rst_n_q;
    assign oBusy   = busy_q;
    assign oReqSrc = src_q;
    assign oDone   = done_q;

endmodule
